// File: rtl/prio_encoder_arb.sv
// prio_encoder_arb: registered N-input priority encoder / arbiter.
// Picks one active request per load, either fixed priority (highest index)
// or round-robin (descending search from rr_ptr with wrap). The winner is
// presented through a valid/ready output register, so there is no
// combinational path from inputs to outputs.
module prio_encoder_arb #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot
);

    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [N-1:0]     grant_onehot_q, grant_onehot_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             load;
    logic [IDX_W-1:0] win_fixed;
    logic [IDX_W-1:0] win_rr;
    logic [IDX_W-1:0] win;

    // Highest set bit of r; later (higher) indices overwrite earlier ones.
    function automatic logic [IDX_W-1:0] fixed_pick(input logic [N-1:0] r);
        logic [IDX_W-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (r[IDX_W'(i)]) w = IDX_W'(i);
        end
        return w;
    endfunction

    // First set bit searching ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] w;
        logic             found;
        int               p;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            p = int'(ptr) - k;
            if (p < 0) p = p + N;
            if (!found && r[IDX_W'(p)]) begin
                w     = IDX_W'(p);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Winner selection and load qualification; a stalled output blocks loads.
    always_comb begin
        win_fixed = fixed_pick(req);
        win_rr    = rr_pick(req, rr_ptr_q);
        win       = mode ? win_rr : win_fixed;
        load      = en & (|req) & (~out_valid_q | out_ready);
    end

    // Next-state of the output register and round-robin pointer.
    always_comb begin
        out_valid_d    = out_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        rr_ptr_d       = rr_ptr_q;
        if (load) begin
            out_valid_d    = 1'b1;
            grant_idx_d    = win;
            grant_onehot_d = {{(N-1){1'b0}}, 1'b1} << win;
            if (mode) begin
                rr_ptr_d = (win == '0) ? IDX_W'(N - 1) : (win - IDX_W'(1));
            end
        end else if (out_valid_q && out_ready) begin
            // Accepted with nothing new: drop valid, keep last index/one-hot.
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops any held grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            rr_ptr_q       <= IDX_W'(N - 1);
        end else begin
            out_valid_q    <= out_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            rr_ptr_q       <= rr_ptr_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Testbench for prio_encoder_arb (N=8): directed scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_prio_encoder_arb;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst;
    logic             en;
    logic             mode;
    logic [N-1:0]     req;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     grant_onehot;

    int n_checks;
    int n_errors;

    // Reference model state
    bit         m_valid;
    int         m_idx;
    logic [7:0] m_oh;
    int         m_ptr;

    prio_encoder_arb #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .req          (req),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule straight from the description of each mode.
    function automatic int model_win(input logic [7:0] r, input bit m, input int ptr);
        int c;
        if (!m) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (ptr - k + N) % N;
                if (r[c]) return c;
            end
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, advance the model, check outputs after the edge.
    task automatic step(input logic r_i, input logic e_i, input logic m_i,
                        input logic [7:0] q_i, input logic rd_i);
        int  g;
        bit  ld;
        rst = r_i; en = e_i; mode = m_i; req = q_i; out_ready = rd_i;
        @(posedge clk);
        if (r_i) begin
            m_valid = 0; m_idx = 0; m_oh = 8'h00; m_ptr = N - 1;
        end else begin
            ld = e_i && (q_i != 0) && (!m_valid || rd_i);
            if (ld) begin
                g       = model_win(q_i, m_i, m_ptr);
                m_valid = 1;
                m_idx   = g;
                m_oh    = 8'(1 << g);
                if (m_i) m_ptr = (g == 0) ? N - 1 : g - 1;
            end else if (m_valid && rd_i) begin
                m_valid = 0;
            end
        end
        #1;
        chk("valid", 32'(out_valid), 32'(m_valid));
        chk("idx", 32'(grant_idx), 32'(m_idx));
        chk("onehot", 32'(grant_onehot), 32'(m_oh));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_valid = 0; m_idx = 0; m_oh = 0; m_ptr = N - 1;
        rst = 1'b1; en = 1'b1; mode = 1'b0; req = 8'hFF; out_ready = 1'b1;

        // 1: reset with requests pending, then first RR grant is 7
        step(1, 1, 0, 8'hFF, 1);
        step(1, 1, 0, 8'hFF, 1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_onehot", 32'(grant_onehot), 32'd0);
        step(0, 1, 1, 8'hFF, 1);
        chk("rr_first", 32'(grant_idx), 32'd7);

        // 2: fixed priority
        step(0, 1, 0, 8'b0010_1100, 1);
        chk("fix_idx5", 32'(grant_idx), 32'd5);
        chk("fix_oh20", 32'(grant_onehot), 32'h20);
        step(0, 1, 0, 8'h01, 1);
        chk("fix_idx0", 32'(grant_idx), 32'd0);
        step(0, 1, 0, 8'h00, 1);
        chk("fix_idle", 32'(out_valid), 32'd0);

        // 3: round-robin fairness from a fresh pointer
        step(1, 1, 0, 8'h00, 1);
        begin
            int exp_seq[6] = '{7, 2, 0, 7, 2, 0};
            for (int i = 0; i < 6; i++) begin
                step(0, 1, 1, 8'b1000_0101, 1);
                chk("rr_seq", 32'(grant_idx), 32'(exp_seq[i]));
                chk("rr_valid", 32'(out_valid), 32'd1);
            end
        end

        // 4: backpressure freezes outputs and pointer
        step(0, 1, 1, 8'h08, 1);
        chk("bp_idx", 32'(grant_idx), 32'd3);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 8'($urandom_range(1, 255)), 0);
            chk("bp_hold", 32'(grant_idx), 32'd3);
        end
        step(0, 1, 1, 8'h48, 1);
        chk("bp_release", 32'(grant_idx), 32'd6);

        // 5: enable gating
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 8'hFF, 1);
            chk("en_off", 32'(out_valid), 32'd0);
        end
        step(0, 1, 0, 8'hFF, 1);
        chk("en_on", 32'(grant_idx), 32'd7);

        // 6: reset during a stall
        step(0, 1, 0, 8'h00, 0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        step(1, 1, 0, 8'hFF, 0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        step(0, 1, 1, 8'h24, 1);
        chk("midrst_rr", 32'(grant_idx), 32'd5);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] q;
            q = 8'($urandom);
            if ($urandom_range(0, 3) == 0) q = q & 8'($urandom);
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 1'($urandom),
                 q,
                 ($urandom_range(0, 9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
